// File: rtl/safebox_pkg.sv
// safebox_pkg
// Shared definitions for the safe box policy blocks.
//   CODE_W      - width of a submitted code (used by the code comparator)
//   state_t     - alarm_trigger state encoding (IDLE / OPEN / ALARM)
//   timer_width - bits needed for a down-counter holding values 0..max(a,b)-1
package safebox_pkg;

    localparam int CODE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OPEN  = 2'd1,
        ST_ALARM = 2'd2
    } state_t;

    // The timer is loaded with (hold - 1), so clog2 of the larger hold
    // is enough; a hold of 1 still needs one bit.
    function automatic int timer_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/hold_timer.sv
// hold_timer
// Loadable down-counter shared by the OPEN and ALARM holds. Counts down
// by one per cycle and rests at zero.
//   clk        in   system clock
//   rst        in   asynchronous active-high reset (clears the count)
//   load       in   load load_value this cycle (wins over counting)
//   load_value in   W  value to load
//   value      out  W  current count
//   zero       out  count is zero
module hold_timer #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic [W-1:0] value,
    output logic         zero
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (load) begin
            value <= load_value;
        end else if (value != '0) begin
            value <= value - W'(1);
        end
    end

    assign zero = (value == '0);

endmodule

// File: rtl/alarm_trigger.sv
// alarm_trigger
// Safe box policy engine: counts consecutive wrong code entries, grants a
// timed unlock on a correct entry and raises a level alarm after
// MAX_FAILS wrong entries in a row.
// Optional feature macro: ALARM_AUTO_CLEAR_EN - when defined, the alarm
// clears itself after ALARM_CYCLES cycles; otherwise it persists until a
// correct entry or reset.
//   clk      in   system clock
//   rst      in   asynchronous active-high reset
//   check    in   one-cycle strobe: a code submission completes
//   match    in   qualifies check: the submitted code is correct
//   close    in   user relocks the box (OPEN only)
//   unlocked out  high while OPEN
//   alarm    out  high while ALARM
//   fail_cnt out  4  consecutive wrong entries, saturates at MAX_FAILS
module alarm_trigger
    import safebox_pkg::*;
#(
    parameter int MAX_FAILS    = 3,
    parameter int OPEN_CYCLES  = 500000,
    parameter int ALARM_CYCLES = 5000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       check,
    input  logic       match,
    input  logic       close,
    output logic       unlocked,
    output logic       alarm,
    output logic [3:0] fail_cnt
);

    localparam int TW = timer_width(OPEN_CYCLES, ALARM_CYCLES);
    localparam logic [TW-1:0] OPEN_LOAD = TW'(OPEN_CYCLES - 1);
`ifdef ALARM_AUTO_CLEAR_EN
    localparam logic [TW-1:0] ALARM_LOAD = TW'(ALARM_CYCLES - 1);
`endif

    state_t        state;
    logic          timer_load;
    logic [TW-1:0] timer_load_value;
    logic [TW-1:0] timer_value;
    logic          timer_zero;
    logic          unused_timer_bits;
    logic [3:0]    fail_next;
    logic          fail_limit;

    assign fail_next  = fail_cnt + 4'd1;
    assign fail_limit = (fail_next == 4'(MAX_FAILS));

    // Only the expiry flag drives decisions; the raw count is not needed.
    assign unused_timer_bits = ^timer_value;

    // The timer is loaded on the same edge that enters a timed state.
    always_comb begin
        timer_load       = 1'b0;
        timer_load_value = OPEN_LOAD;
        if (state == ST_IDLE && check) begin
            if (match) begin
                timer_load = 1'b1;
            end
`ifdef ALARM_AUTO_CLEAR_EN
            else if (fail_limit) begin
                timer_load       = 1'b1;
                timer_load_value = ALARM_LOAD;
            end
`endif
        end
    end

    hold_timer #(
        .W (TW)
    ) u_hold_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (timer_load),
        .load_value (timer_load_value),
        .value      (timer_value),
        .zero       (timer_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            unlocked <= 1'b0;
            alarm    <= 1'b0;
            fail_cnt <= 4'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (check) begin
                        if (match) begin
                            state    <= ST_OPEN;
                            unlocked <= 1'b1;
                            fail_cnt <= 4'd0;
                        end else begin
                            fail_cnt <= fail_next;
                            if (fail_limit) begin
                                state <= ST_ALARM;
                                alarm <= 1'b1;
                            end
                        end
                    end
                end
                ST_OPEN: begin
                    // Submissions are ignored while open.
                    if (close || timer_zero) begin
                        state    <= ST_IDLE;
                        unlocked <= 1'b0;
                    end
                end
                ST_ALARM: begin
                    // A correct entry only disarms; a second one opens.
                    if (check && match) begin
                        state    <= ST_IDLE;
                        alarm    <= 1'b0;
                        fail_cnt <= 4'd0;
                    end
`ifdef ALARM_AUTO_CLEAR_EN
                    else if (timer_zero) begin
                        state    <= ST_IDLE;
                        alarm    <= 1'b0;
                        fail_cnt <= 4'd0;
                    end
`endif
                end
                default: begin
                    state    <= ST_IDLE;
                    unlocked <= 1'b0;
                    alarm    <= 1'b0;
                    fail_cnt <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alarm_trigger.sv
// tb_alarm_trigger
// Self-checking bench for alarm_trigger with MAX_FAILS=3, OPEN_CYCLES=4,
// ALARM_CYCLES=8. A behavioural model tracks remaining unlock/alarm cycles
// and is compared with the DUT every cycle; directed scenarios add literal
// expectations, followed by a randomized phase.
module tb_alarm_trigger;

    localparam int MAX_FAILS    = 3;
    localparam int OPEN_CYCLES  = 4;
    localparam int ALARM_CYCLES = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       check = 1'b0;
    logic       match = 1'b0;
    logic       close = 1'b0;
    logic       unlocked;
    logic       alarm;
    logic [3:0] fail_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: cycles of unlock still to show, alarm flag, fail count.
    int m_open_left = 0;
    int m_alarm     = 0;
    int m_fail      = 0;
`ifdef ALARM_AUTO_CLEAR_EN
    int m_alarm_left = 0;
`endif

    alarm_trigger #(
        .MAX_FAILS    (MAX_FAILS),
        .OPEN_CYCLES  (OPEN_CYCLES),
        .ALARM_CYCLES (ALARM_CYCLES)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .check    (check),
        .match    (match),
        .close    (close),
        .unlocked (unlocked),
        .alarm    (alarm),
        .fail_cnt (fail_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model of the policy rules.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_open_left <= 0;
            m_alarm     <= 0;
            m_fail      <= 0;
`ifdef ALARM_AUTO_CLEAR_EN
            m_alarm_left <= 0;
`endif
        end else if (m_open_left > 0) begin
            if (close || m_open_left == 1) m_open_left <= 0;
            else m_open_left <= m_open_left - 1;
        end else if (m_alarm != 0) begin
            if (check && match) begin
                m_alarm <= 0;
                m_fail  <= 0;
            end
`ifdef ALARM_AUTO_CLEAR_EN
            else if (m_alarm_left == 1) begin
                m_alarm <= 0;
                m_fail  <= 0;
            end else begin
                m_alarm_left <= m_alarm_left - 1;
            end
`endif
        end else if (check) begin
            if (match) begin
                m_open_left <= OPEN_CYCLES;
                m_fail      <= 0;
            end else begin
                m_fail <= m_fail + 1;
                if (m_fail + 1 == MAX_FAILS) begin
                    m_alarm <= 1;
`ifdef ALARM_AUTO_CLEAR_EN
                    m_alarm_left <= ALARM_CYCLES;
`endif
                end
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        chk("mon_unlocked", int'(unlocked), (m_open_left > 0) ? 1 : 0);
        chk("mon_alarm",    int'(alarm),    m_alarm);
        chk("mon_fail_cnt", int'(fail_cnt), m_fail);
    end

    // Drive one cycle of inputs from a negedge, return at the next negedge.
    task automatic step(input logic c, input logic m, input logic cl);
        check = c;
        match = m;
        close = cl;
        @(negedge clk);
        check = 1'b0;
        match = 1'b0;
        close = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int hi;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("reset_unlocked", int'(unlocked), 0);
        chk("reset_alarm", int'(alarm), 0);
        chk("reset_fail_cnt", int'(fail_cnt), 0);
        rst = 1'b0;
        idle(2);

        // Correct entry: unlocked for exactly 4 cycles.
        step(1'b1, 1'b1, 1'b0);
        chk("open_c1", int'(unlocked), 1);
        for (int i = 2; i <= 4; i++) begin
            step(1'b0, 1'b0, 1'b0);
            chk("open_cn", int'(unlocked), 1);
        end
        step(1'b0, 1'b0, 1'b0);
        chk("open_end", int'(unlocked), 0);
        chk("open_fail", int'(fail_cnt), 0);

        // Two wrong then a correct entry.
        step(1'b1, 1'b0, 1'b0);
        chk("wrong1", int'(fail_cnt), 1);
        step(1'b1, 1'b0, 1'b0);
        chk("wrong2", int'(fail_cnt), 2);
        step(1'b1, 1'b1, 1'b0);
        chk("right_fail", int'(fail_cnt), 0);
        chk("right_unlocked", int'(unlocked), 1);
        chk("right_alarm", int'(alarm), 0);
        idle(6);

        // Three wrong entries raise the alarm; a fourth changes nothing.
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk("alarm_on", int'(alarm), 1);
        chk("alarm_fail", int'(fail_cnt), 3);
        step(1'b1, 1'b0, 1'b0);
        chk("alarm_4th", int'(alarm), 1);
        chk("alarm_4th_fail", int'(fail_cnt), 3);
        step(1'b1, 1'b1, 1'b0);
        chk("disarm_alarm", int'(alarm), 0);
        chk("disarm_unlocked", int'(unlocked), 0);
        chk("disarm_fail", int'(fail_cnt), 0);
        step(1'b0, 1'b0, 1'b0);
        chk("disarm_still_locked", int'(unlocked), 0);

        // Alarm duration.
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
`ifdef ALARM_AUTO_CLEAR_EN
        hi = (alarm == 1'b1) ? 1 : 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, 1'b0);
            if (alarm == 1'b1) hi++;
        end
        chk("autoclear_cycles", hi, 8);
        chk("autoclear_fail", int'(fail_cnt), 0);
`else
        hi = 0;
        idle(100);
        chk("alarm_persists", int'(alarm), 1);
        step(1'b1, 1'b1, 1'b0);
        chk("persist_disarm", int'(alarm), 0);
`endif
        idle(2);

        // Close on the 2nd OPEN cycle, with a wrong check alongside.
        step(1'b1, 1'b1, 1'b0);
        chk("close_c1", int'(unlocked), 1);
        step(1'b1, 1'b0, 1'b1);
        chk("close_fall", int'(unlocked), 0);
        chk("close_fail", int'(fail_cnt), 0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk("open_ignore_check", int'(fail_cnt), 0);
        chk("open_ignore_unl", int'(unlocked), 1);
        idle(5);

        // Async reset mid-ALARM.
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("rst_alarm_alarm", int'(alarm), 0);
        chk("rst_alarm_fail", int'(fail_cnt), 0);
        chk("rst_alarm_unl", int'(unlocked), 0);
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 1'b1, 1'b0);
        chk("post_rst_open", int'(unlocked), 1);

        // Async reset mid-OPEN.
        #2 rst = 1'b1;
        #1;
        chk("rst_open_unl", int'(unlocked), 0);
        chk("rst_open_alarm", int'(alarm), 0);
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 1'b1, 1'b0);
        chk("post_rst2_open", int'(unlocked), 1);
        idle(5);

        // Randomized traffic, checked by the per-cycle model comparison.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                #2 rst = 1'b1;
                #1;
                chk("rand_rst_unl", int'(unlocked), 0);
                @(negedge clk);
                rst = 1'b0;
            end else begin
                step(($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0,
                     ($urandom_range(0, 1) == 0) ? 1'b1 : 1'b0,
                     ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
